// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction loader.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned BYTE_W  = 8;

    // Word value that ends a load early when zero-termination is built in
    localparam logic [INSTR_W-1:0] INSTR_TERM = 32'h0;

    typedef enum logic {
        LD_LOAD,
        LD_DONE
    } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// Byte counter and shift register that assemble four bytes MSB-first into one
// instruction word. o_word_valid is high in the cycle the fourth byte is present.
module byte_packer
    import cpu_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_reset,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [BYTE_W-1:0]  i_byte,
    output logic               o_word_valid,
    output logic [INSTR_W-1:0] o_word
);

    logic [1:0]                r_byte_cnt;
    logic [INSTR_W-BYTE_W-1:0] r_shift;

    // Count bytes and shift them in; wrap after the fourth byte of each word
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= '0;
        end else if (i_clr) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= '0;
        end else if (i_en) begin
            if (r_byte_cnt == 2'd3) begin
                r_byte_cnt <= 2'd0;
                r_shift    <= '0;
            end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_shift    <= {r_shift[INSTR_W-2*BYTE_W-1:0], i_byte};
            end
        end
    end

    // The completed word uses the live byte as its least significant byte
    always_comb begin
        o_word_valid = i_en && (r_byte_cnt == 2'd3);
        o_word       = {r_shift, i_byte};
    end

endmodule

// File: rtl/instr_byte_loader.sv
// Streams a program byte-by-byte into instruction memory and holds the core
// until loading finishes. Optional macro INSTR_LOADER_ZERO_TERM_EN makes an
// all-zero word end the load without being written.
module instr_byte_loader
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic               sys_clk,
    input  logic               sys_reset,
    input  logic [BYTE_W-1:0]  instr_i,
    input  logic               reload_i,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_waddr_o,
    output logic [INSTR_W-1:0] imem_wdata_o,
    output logic               load_done_o,
    output logic               cpu_run_o,
    output logic [ADDR_W:0]    word_count_o
);

    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

    ld_state_e          r_state;
    ld_state_e          w_state_d;
    logic               w_write;
    logic               w_pack_en;
    logic               w_word_valid;
    logic [INSTR_W-1:0] w_word;
    logic [ADDR_W:0]    w_cnt_inc;

    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [INSTR_W-1:0] r_wdata;
    logic               r_run;
    logic [ADDR_W:0]    r_word_cnt;

    // A reload edge samples no byte; the next byte is taken on the following edge
    assign w_pack_en = (r_state == LD_LOAD) && !reload_i;
    assign w_cnt_inc = r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};

    byte_packer u_packer (
        .sys_clk      (sys_clk),
        .sys_reset    (sys_reset),
        .i_en         (w_pack_en),
        .i_clr        (reload_i),
        .i_byte       (instr_i),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Next state and write decision; reload overrides everything
    always_comb begin
        w_state_d = r_state;
        w_write   = 1'b0;
        if (reload_i) begin
            w_state_d = LD_LOAD;
        end else if ((r_state == LD_LOAD) && w_word_valid) begin
`ifdef INSTR_LOADER_ZERO_TERM_EN
            if (w_word == INSTR_TERM) begin
                w_state_d = LD_DONE;
            end else begin
                w_write = 1'b1;
                if (w_cnt_inc == DEPTH_CNT) begin
                    w_state_d = LD_DONE;
                end
            end
`else
            w_write = 1'b1;
            if (w_cnt_inc == DEPTH_CNT) begin
                w_state_d = LD_DONE;
            end
`endif
        end
    end

    // State, write port registers, word counter and delayed run enable
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_state    <= LD_LOAD;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_run      <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_we    <= w_write;
            if (reload_i) begin
                r_run      <= 1'b0;
                r_word_cnt <= '0;
            end else begin
                // Run follows DONE by one cycle so fetch never meets the last write
                r_run <= (r_state == LD_DONE);
                if (w_write) begin
                    r_waddr    <= r_word_cnt[ADDR_W-1:0];
                    r_wdata    <= w_word;
                    r_word_cnt <= w_cnt_inc;
                end
            end
        end
    end

    // Registered outputs; done is a direct decode of the state
    always_comb begin
        imem_we_o    = r_we;
        imem_waddr_o = r_waddr;
        imem_wdata_o = r_wdata;
        load_done_o  = (r_state == LD_DONE);
        cpu_run_o    = r_run;
        word_count_o = r_word_cnt;
    end

endmodule

// File: tb/tb_instr_byte_loader.sv
// Table-driven bench for instr_byte_loader with DEPTH=4. Expectations follow
// INSTR_LOADER_ZERO_TERM_EN when the bench is built with it.
module tb_instr_byte_loader;

    logic        sys_clk = 1'b0;
    logic        sys_reset = 1'b1;
    logic [7:0]  instr_i = 8'h00;
    logic        reload_i = 1'b0;
    logic        imem_we_o;
    logic [1:0]  imem_waddr_o;
    logic [31:0] imem_wdata_o;
    logic        load_done_o;
    logic        cpu_run_o;
    logic [2:0]  word_count_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  b;
        logic        rl;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        done;
        logic        run;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vec_q[$];

    instr_byte_loader #(
        .DEPTH  (4),
        .ADDR_W (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_reset    (sys_reset),
        .instr_i      (instr_i),
        .reload_i     (reload_i),
        .imem_we_o    (imem_we_o),
        .imem_waddr_o (imem_waddr_o),
        .imem_wdata_o (imem_wdata_o),
        .load_done_o  (load_done_o),
        .cpu_run_o    (cpu_run_o),
        .word_count_o (word_count_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input logic rl, input logic we,
                       input logic [1:0] addr, input logic [31:0] data,
                       input logic done, input logic run, input logic [2:0] cnt);
        vec_t v;
        v.b = b; v.rl = rl; v.we = we; v.addr = addr; v.data = data;
        v.done = done; v.run = run; v.cnt = cnt;
        vec_q.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [1:0] addr,
                           input logic [31:0] data, input logic done, input logic run,
                           input logic [2:0] cnt);
        chk({tag, ".we"},   {31'd0, imem_we_o},   {31'd0, we});
        chk({tag, ".addr"}, {30'd0, imem_waddr_o}, {30'd0, addr});
        chk({tag, ".data"}, imem_wdata_o,          data);
        chk({tag, ".done"}, {31'd0, load_done_o}, {31'd0, done});
        chk({tag, ".run"},  {31'd0, cpu_run_o},   {31'd0, run});
        chk({tag, ".cnt"},  {29'd0, word_count_o}, {29'd0, cnt});
    endtask

    // Drive each record, clock once, compare 1 time unit after the edge
    task automatic run_vectors(input string tag);
        for (int i = 0; i < vec_q.size(); i++) begin
            instr_i  = vec_q[i].b;
            reload_i = vec_q[i].rl;
            @(posedge sys_clk);
            #1;
            chk_all($sformatf("%s[%0d]", tag, i), vec_q[i].we, vec_q[i].addr,
                    vec_q[i].data, vec_q[i].done, vec_q[i].run, vec_q[i].cnt);
        end
        reload_i = 1'b0;
        vec_q.delete();
    endtask

    task automatic do_reset(input string tag);
        sys_reset = 1'b1;
        reload_i  = 1'b0;
        instr_i   = 8'h00;
        @(posedge sys_clk);
        #1;
        chk_all(tag, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        sys_reset = 1'b0;
    endtask

    initial begin
        // Full load of four words, then extra bytes that must be ignored
        do_reset("rst_a");
        add(8'h00, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'hA0, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h81, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h13, 0, 1, 0, 32'h00A08113, 0, 0, 1);
        add(8'hDE, 0, 0, 0, 32'h00A08113, 0, 0, 1);
        add(8'hAD, 0, 0, 0, 32'h00A08113, 0, 0, 1);
        add(8'hBE, 0, 0, 0, 32'h00A08113, 0, 0, 1);
        add(8'hEF, 0, 1, 1, 32'hDEADBEEF, 0, 0, 2);
        add(8'h01, 0, 0, 1, 32'hDEADBEEF, 0, 0, 2);
        add(8'h02, 0, 0, 1, 32'hDEADBEEF, 0, 0, 2);
        add(8'h03, 0, 0, 1, 32'hDEADBEEF, 0, 0, 2);
        add(8'h04, 0, 1, 2, 32'h01020304, 0, 0, 3);
        add(8'hCA, 0, 0, 2, 32'h01020304, 0, 0, 3);
        add(8'hFE, 0, 0, 2, 32'h01020304, 0, 0, 3);
        add(8'hF0, 0, 0, 2, 32'h01020304, 0, 0, 3);
        add(8'h0D, 0, 1, 3, 32'hCAFEF00D, 1, 0, 4);
        add(8'h55, 0, 0, 3, 32'hCAFEF00D, 1, 1, 4);
        add(8'h66, 0, 0, 3, 32'hCAFEF00D, 1, 1, 4);
        add(8'h77, 0, 0, 3, 32'hCAFEF00D, 1, 1, 4);
        add(8'h88, 0, 0, 3, 32'hCAFEF00D, 1, 1, 4);
        add(8'h99, 0, 0, 3, 32'hCAFEF00D, 1, 1, 4);
        run_vectors("full");

        // Reload from DONE drops done/run and restarts at address 0
        instr_i  = 8'h12;
        reload_i = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("reload_done.done", {31'd0, load_done_o}, 32'd0);
        chk("reload_done.run",  {31'd0, cpu_run_o},   32'd0);
        chk("reload_done.cnt",  {29'd0, word_count_o}, 32'd0);
        chk("reload_done.we",   {31'd0, imem_we_o},   32'd0);
        reload_i = 1'b0;
        add(8'h0A, 0, 0, 3, 32'hCAFEF00D, 0, 0, 0);
        add(8'h0B, 0, 0, 3, 32'hCAFEF00D, 0, 0, 0);
        add(8'h0C, 0, 0, 3, 32'hCAFEF00D, 0, 0, 0);
        add(8'h0D, 0, 1, 0, 32'h0A0B0C0D, 0, 0, 1);
        run_vectors("after_reload");

        // Reload coinciding with the fourth byte of word 1 discards that word
        do_reset("rst_b");
        add(8'h11, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h22, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h33, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h44, 0, 1, 0, 32'h11223344, 0, 0, 1);
        add(8'h55, 0, 0, 0, 32'h11223344, 0, 0, 1);
        add(8'h66, 0, 0, 0, 32'h11223344, 0, 0, 1);
        add(8'h77, 0, 0, 0, 32'h11223344, 0, 0, 1);
        add(8'h88, 1, 0, 0, 32'h11223344, 0, 0, 0);
        add(8'h99, 0, 0, 0, 32'h11223344, 0, 0, 0);
        add(8'hAA, 0, 0, 0, 32'h11223344, 0, 0, 0);
        add(8'hBB, 0, 0, 0, 32'h11223344, 0, 0, 0);
        add(8'hCC, 0, 1, 0, 32'h99AABBCC, 0, 0, 1);
        run_vectors("reload_b3");

        // Zero word as the third word
        do_reset("rst_c");
        add(8'h01, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h23, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h45, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h67, 0, 1, 0, 32'h01234567, 0, 0, 1);
        add(8'h89, 0, 0, 0, 32'h01234567, 0, 0, 1);
        add(8'hAB, 0, 0, 0, 32'h01234567, 0, 0, 1);
        add(8'hCD, 0, 0, 0, 32'h01234567, 0, 0, 1);
        add(8'hEF, 0, 1, 1, 32'h89ABCDEF, 0, 0, 2);
        add(8'h00, 0, 0, 1, 32'h89ABCDEF, 0, 0, 2);
        add(8'h00, 0, 0, 1, 32'h89ABCDEF, 0, 0, 2);
        add(8'h00, 0, 0, 1, 32'h89ABCDEF, 0, 0, 2);
`ifdef INSTR_LOADER_ZERO_TERM_EN
        add(8'h00, 0, 0, 1, 32'h89ABCDEF, 1, 0, 2);
        add(8'h76, 0, 0, 1, 32'h89ABCDEF, 1, 1, 2);
        add(8'h54, 0, 0, 1, 32'h89ABCDEF, 1, 1, 2);
        add(8'h32, 0, 0, 1, 32'h89ABCDEF, 1, 1, 2);
        add(8'h10, 0, 0, 1, 32'h89ABCDEF, 1, 1, 2);
`else
        add(8'h00, 0, 1, 2, 32'h00000000, 0, 0, 3);
        add(8'h76, 0, 0, 2, 32'h00000000, 0, 0, 3);
        add(8'h54, 0, 0, 2, 32'h00000000, 0, 0, 3);
        add(8'h32, 0, 0, 2, 32'h00000000, 0, 0, 3);
        add(8'h10, 0, 1, 3, 32'h76543210, 1, 0, 4);
`endif
        run_vectors("zero_word");

        // Asynchronous reset between edges while a write strobe is showing
        do_reset("rst_d");
        add(8'h11, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h22, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h33, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'h44, 0, 1, 0, 32'h11223344, 0, 0, 1);
        add(8'h55, 0, 0, 0, 32'h11223344, 0, 0, 1);
        add(8'h66, 0, 0, 0, 32'h11223344, 0, 0, 1);
        add(8'h77, 0, 0, 0, 32'h11223344, 0, 0, 1);
        add(8'h88, 0, 1, 1, 32'h55667788, 0, 0, 2);
        add(8'h99, 0, 0, 1, 32'h55667788, 0, 0, 2);
        run_vectors("pre_async");
        #3;
        sys_reset = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        #2;
        sys_reset = 1'b0;
        add(8'hA1, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'hB2, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'hC3, 0, 0, 0, 32'h0,        0, 0, 0);
        add(8'hD4, 0, 1, 0, 32'hA1B2C3D4, 0, 0, 1);
        run_vectors("post_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_byte_loader.md
# instr_byte_loader

- Streams a program into instruction memory, one byte per clock, and holds the core until the program is complete.
- Collects bytes from the 8-bit `instr_i` pin, assembles them MSB-first into 32-bit words and writes each word into the instruction memory.
- Sits between the top-level `instr_i` pin and the instruction-memory write port inside `RISC_V_CPU`.
- Releases the pipeline via `cpu_run_o` once loading completes.

## Interface

Parameters:

- `DEPTH`, 64, number of instruction words; loading stops after this many words.
- `ADDR_W`, 6, word-address width; requires `DEPTH <= 2**ADDR_W`.

Ports:

- Clock and reset: one clock; reset is asynchronous and active-high.
  - `sys_clk`  in  1  system clock; all state updates on the rising edge.
  - `sys_reset`  in  1  asynchronous, active-high reset.
- `instr_i`  in  8  program byte; sampled every rising edge while in LOAD.
- `reload_i`  in  1  synchronous request to restart loading from word 0.
- `imem_we_o`  out  1  one-cycle instruction-memory write strobe.
- `imem_waddr_o`  out  ADDR_W  word address of the write.
- `imem_wdata_o`  out  32  assembled instruction word.
- `load_done_o`  out  1  high while in DONE.
- `cpu_run_o`  out  1  pipeline enable; the core's PC and pipeline registers hold while this is low.
- `word_count_o`  out  ADDR_W+1  number of words written in the current load.

## Operation

States:

- LOAD is entered on reset and on `reload_i`.
- DONE is entered when the final word is written or when a terminator word is sampled.

Byte and word assembly:

- A 2-bit `byte_cnt` and a 24-bit shift register collect bytes.
  - Byte 0 → bits [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
- On the edge that samples byte 3:
  - Register `imem_wdata_o = {shift[23:0], instr_i}`.
  - Register `imem_waddr_o = word_cnt`.
  - Set `imem_we_o = 1`.
  - Increment `word_cnt`.
  - Reset `byte_cnt` to 0.
- `word_cnt` never wraps. When it reaches `DEPTH`, the FSM moves to DONE on that same edge.

DONE state:

- `instr_i` is ignored and no writes occur.
- `cpu_run_o` rises one cycle after `load_done_o`. The core therefore never fetches in the same cycle as the last write.

`reload_i`:

- Synchronous; takes priority over every other event.
- Clears `byte_cnt`, `word_cnt`, the shift register, `load_done_o` and `cpu_run_o`, and enters LOAD.
- If it coincides with a 4th byte, that word is discarded and `imem_we_o` stays 0.
- The first byte sampled after a reload is the edge following the one that saw `reload_i`.

Reset mid-load:

- Immediately clears all state and outputs.
- Partial words are lost. Memory already written is not cleared.

## Timing

- Reset values: `imem_we_o=0`, `imem_waddr_o=0`, `imem_wdata_o=0`, `load_done_o=0`, `cpu_run_o=0`, `word_count_o=0`, state LOAD, `byte_cnt=0`.
- The first byte is sampled on the first rising edge with `sys_reset` low.
- Write latency:
  - `imem_we_o` is high for exactly the one cycle after the edge that sampled byte 3.
  - Writes occur at most every 4 cycles.
- A full load of `DEPTH` words:
  - The last write strobe is visible in cycle 4·DEPTH, counting the first sample edge as cycle 1.
  - `load_done_o` is high from cycle 4·DEPTH.
  - `cpu_run_o` is high from cycle 4·DEPTH+1.
- No backpressure. Bytes arrive unconditionally every cycle in LOAD.

## Configuration

Macro `INSTR_LOADER_ZERO_TERM_EN`.

- When defined:
  - A fully assembled word equal to `32'h0000_0000` terminates the load.
  - The terminator word is not written and not counted.
  - DONE is entered on that edge.
  - `word_count_o` reports the words before the terminator.
- When undefined:
  - Zero words are written like any other word.
  - Loading always runs to `DEPTH` words.

## Structure

- Shared package `cpu_pkg` holds:
  - the state enum (`LD_LOAD`, `LD_DONE`);
  - `INSTR_W=32`;
  - `BYTE_W=8`;
  - the terminator constant `INSTR_TERM=32'h0`.
- One natural sub-module: `byte_packer`, covering the byte counter, the shift register and the word-valid pulse. The FSM and address counter stay in the top.

## Test plan

- Bytes `8'h00,8'hA0,8'h81,8'h13` after reset → a single write pulse one cycle after the 4th sample, with `imem_waddr_o=0` and `imem_wdata_o=32'h00A08113`.
- DEPTH=4, 16 bytes streamed →
  - writes to addresses 0–3;
  - `load_done_o` high in cycle 16;
  - `cpu_run_o` high in cycle 17;
  - `word_count_o=4`;
  - further bytes cause no writes.
- With `INSTR_LOADER_ZERO_TERM_EN`, two nonzero words then `32'h0` →
  - 2 writes;
  - DONE with `word_count_o=2`;
  - no write for the zero word.
- Without the macro, same stream → the zero word is written at address 2 and loading continues.
- `reload_i` asserted on the edge sampling byte 3 of word 1 → no write for word 1, counters return to 0, and the next 4 bytes write address 0.
- `sys_reset` pulsed asynchronously mid-word (between edges) → all outputs go to 0 immediately, and loading restarts at address 0 after release.
